pattern_detector_param: RTL and testbench

Parametrised serial pattern detector. It compares a `PAT_W`-bit sliding window of a qualified serial bit stream against a runtime-programmable pattern with per-bit don't-care mask. It supports overlapping and non-overlapping match modes, and keeps a saturating match counter. It sits on the serial receive path as the configurable successor of the fixed-sequence detector FSMs, and is configured by a local control interface.

---
 rtl/pattern_detector_param.sv | 98 +++++++++
 tb/tb_pattern_detector_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - programmable sliding-window serial pattern detector
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   valid_i, data_i           qualified serial bit stream
//   cfg_load_i                load pattern_i/mask_i/overlap_i and flush history
//   pattern_i, mask_i         pattern (bit PAT_W-1 oldest), mask (1 = don't care)
//   overlap_i                 1 = overlapping matches, 0 = non-overlapping
//   clear_i                   synchronous clear of the match counter
//   match_o                   one-cycle registered match pulse
//   match_cnt_o, cnt_sat_o    saturating match count and its at-maximum flag

module pattern_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             cfg_load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    input  logic             overlap_i,
    input  logic             clear_i,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  mask_q;
    logic              ovl_q;
    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              shift_en;
    logic              hit;
    logic [CNT_W-1:0]  cnt_next;

    always_comb begin
        shift_en = valid_i & ~cfg_load_i;
        win_next = {win[PAT_W-2:0], data_i};
        // fill counts bits before this one, so PAT_W-1 means the new window is fully fresh.
        hit = shift_en && (fill >= FILL_THR) &&
              (((win_next ^ pat_q) & ~mask_q) == '0);

        fill_next = fill;
        if (cfg_load_i) begin
            fill_next = '0;
        end else if (hit && !ovl_q) begin
            // Old window bits stay in win but are ignored until PAT_W new bits arrive.
            fill_next = '0;
        end else if (shift_en && (fill != FILL_FULL)) begin
            fill_next = fill + 1'b1;
        end

        cnt_next = match_cnt_o;
        if (clear_i) begin
            cnt_next = '0;
        end else if (hit && (match_cnt_o != CNT_MAX)) begin
            cnt_next = match_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pat_q       <= '0;
            mask_q      <= '0;
            ovl_q       <= 1'b1;
            win         <= '0;
            fill        <= '0;
            match_o     <= 1'b0;
            match_cnt_o <= '0;
            cnt_sat_o   <= 1'b0;
        end else begin
            if (cfg_load_i) begin
                pat_q  <= pattern_i;
                mask_q <= mask_i;
                ovl_q  <= overlap_i;
                win    <= '0;
            end else if (shift_en) begin
                win <= win_next;
            end
            fill        <= fill_next;
            match_o     <= hit;
            match_cnt_o <= cnt_next;
            cnt_sat_o   <= (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - scoreboard bench for pattern_detector_param

module tb_pattern_detector_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             valid_i;
    logic             data_i;
    logic             cfg_load_i;
    logic [PAT_W-1:0] pattern_i;
    logic [PAT_W-1:0] mask_i;
    logic             overlap_i;
    logic             clear_i;
    logic             match_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic             cnt_sat_o;

    pattern_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .cfg_load_i  (cfg_load_i),
        .pattern_i   (pattern_i),
        .mask_i      (mask_i),
        .overlap_i   (overlap_i),
        .clear_i     (clear_i),
        .match_o     (match_o),
        .match_cnt_o (match_cnt_o),
        .cnt_sat_o   (cnt_sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit match;
        int cnt;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: bits received since the last flush, kept as a list.
    bit             m_hist[$];
    bit [PAT_W-1:0] m_pat;
    bit [PAT_W-1:0] m_mask;
    bit             m_ovl;
    int             m_cnt;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat  = '0;
        m_mask = '0;
        m_ovl  = 1'b1;
        m_cnt  = 0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit load,
                              input bit [PAT_W-1:0] p, input bit [PAT_W-1:0] m,
                              input bit o, input bit clr, output exp_t e);
        bit ok;
        e.match = 1'b0;
        if (load) begin
            m_pat  = p;
            m_mask = m;
            m_ovl  = o;
            m_hist.delete();
        end else if (v) begin
            m_hist.push_back(d);
            if (m_hist.size() >= PAT_W) begin
                ok = 1'b1;
                // position i of the pattern is the bit received i steps before the newest
                for (int i = 0; i < PAT_W; i++) begin
                    if (!m_mask[i] && (m_hist[m_hist.size() - 1 - i] != m_pat[i])) ok = 1'b0;
                end
                e.match = ok;
                if (ok && !m_ovl) m_hist.delete();
            end
            while (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        end
        if (clr) m_cnt = 0;
        else if (e.match && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        e.cnt = m_cnt;
        e.sat = (m_cnt == CNT_MAX);
    endtask

    task automatic drive(input bit v, input bit d, input bit load,
                         input bit [PAT_W-1:0] p, input bit [PAT_W-1:0] m,
                         input bit o, input bit clr);
        exp_t e;
        valid_i    = v;
        data_i     = d;
        cfg_load_i = load;
        pattern_i  = p;
        mask_i     = m;
        overlap_i  = o;
        clear_i    = clr;
        model_step(v, d, load, p, m, o, clr, e);
        @(posedge clk_i);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic bit_in(input bit d);
        drive(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load_cfg(input bit [PAT_W-1:0] p, input bit [PAT_W-1:0] m, input bit o);
        drive(1'b1, 1'b1, 1'b1, p, m, o, 1'b1);
    endtask

    task automatic bits(input bit [31:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(seq[i]);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("match_o", int'(match_o), int'(e.match));
            check("match_cnt_o", int'(match_cnt_o), e.cnt);
            check("cnt_sat_o", int'(cnt_sat_o), int'(e.sat));
        end
    end

    initial begin
        reset_i    = 1'b1;
        valid_i    = 1'b0;
        data_i     = 1'b0;
        cfg_load_i = 1'b0;
        pattern_i  = '0;
        mask_i     = '0;
        overlap_i  = 1'b0;
        clear_i    = 1'b0;
        model_reset();
        #1;
        check("reset_match", int'(match_o), 0);
        check("reset_cnt", int'(match_cnt_o), 0);
        check("reset_sat", int'(cnt_sat_o), 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // overlapping detection
        load_cfg(4'b1011, 4'b0000, 1'b1);
        bits(32'b1011011, 7);
        check("ovl_cnt", int'(match_cnt_o), 2);

        // non-overlapping detection
        load_cfg(4'b1011, 4'b0000, 1'b0);
        bits(32'b1011011, 7);
        check("novl_cnt1", int'(match_cnt_o), 1);
        bits(32'b1011, 4);
        check("novl_cnt2", int'(match_cnt_o), 2);

        // mask with gaps between valid bits
        load_cfg(4'b1001, 4'b0110, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(1'b1);
            idle();
        end
        check("mask_gap_cnt", int'(match_cnt_o), 1);

        // config load mid-stream discards history and the load-cycle bit
        load_cfg(4'b1011, 4'b0000, 1'b1);
        bits(32'b101, 3);
        load_cfg(4'b1011, 4'b0000, 1'b1);
        check("load_nomatch", int'(match_o), 0);
        bits(32'b1011, 4);
        check("load_match", int'(match_o), 1);

        // saturation, then clear together with a hit
        load_cfg(4'b0000, 4'b1111, 1'b1);
        bits(32'hFF, 8);
        check("sat_cnt", int'(match_cnt_o), CNT_MAX);
        check("sat_flag", int'(cnt_sat_o), 1);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("clr_hit_match", int'(match_o), 1);
        check("clr_hit_cnt", int'(match_cnt_o), 0);

        // asynchronous reset mid-stream
        load_cfg(4'b1011, 4'b0000, 1'b1);
        bits(32'b1011101, 7);
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("areset_match", int'(match_o), 0);
        check("areset_cnt", int'(match_cnt_o), 0);
        check("areset_sat", int'(cnt_sat_o), 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        load_cfg(4'b1011, 4'b0000, 1'b1);
        bit_in(1'b1);
        check("areset_nomatch", int'(match_o), 0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit             v, d, ld, o, clr;
            bit [PAT_W-1:0] p, m;
            v   = ($urandom_range(0, 3) != 0);
            d   = $urandom_range(0, 1);
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 19) == 0);
            p   = PAT_W'($urandom);
            m   = PAT_W'($urandom) & PAT_W'($urandom);
            o   = $urandom_range(0, 1);
            drive(v, d, ld, p, m, o, clr);
        end
        idle();

        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk_i);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
